// File: rtl/mux_ser_pkg.sv
// ============================================================================
// mux_ser_pkg : shared constants for the 8:1 mux serializer sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

package mux_ser_pkg;

  // FSM encoding; 2'd3 is illegal and recovers to IDLE
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam int BIT_CNT_W = 3;
  localparam int GAP_CNT_W = 4;

  localparam logic [2:0] SEL_FIRST_LSB = 3'd0;
  localparam logic [2:0] SEL_FIRST_MSB = 3'd7;

  function automatic logic [2:0] sel_step(input logic [2:0] sel, input logic lsb_first);
    return lsb_first ? (sel + 3'd1) : (sel - 3'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mux8_serial_tx.sv
// ============================================================================
// mux8_serial_tx : sequencer plus the 8:1 mux it drives. Rev 1.0
// ============================================================================
`default_nettype none

module mux8_serial_tx #(
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       tick,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       ser_last,
  output logic       busy
);

  logic [7:0] mux_din;
  logic [2:0] mux_sel;
  logic       mux_z;

  assign mux_z = mux_din[mux_sel];

  mux8_serializer_ctrl #(
    .LSB_FIRST (LSB_FIRST),
    .GAP_TICKS (GAP_TICKS)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .tick      (tick),
    .mux_din   (mux_din),
    .mux_sel   (mux_sel),
    .mux_z     (mux_z),
    .ser_out   (ser_out),
    .ser_valid (ser_valid),
    .ser_last  (ser_last),
    .busy      (busy)
  );

endmodule

`default_nettype wire

// File: rtl/mux8_serializer_ctrl.sv
// ============================================================================
// mux8_serializer_ctrl : holds a word on the 8:1 mux, walks its select once
// per tick and registers the mux output as a serial stream. Rev 1.0
// ============================================================================
`default_nettype none

module mux8_serializer_ctrl
  import mux_ser_pkg::*;
#(
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       tick,
  output logic [7:0] mux_din,
  output logic [2:0] mux_sel,
  input  logic       mux_z,
  output logic       ser_out,
  output logic       ser_valid,
  output logic       ser_last,
  output logic       busy
);

  localparam logic [2:0] SEL_START = LSB_FIRST ? SEL_FIRST_LSB : SEL_FIRST_MSB;
  localparam bit         SKIP_GAP  = (GAP_TICKS == 0);
  localparam int         GAP_LAST_I = SKIP_GAP ? 0 : int'(GAP_TICKS) - 1;
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_LAST_I[GAP_CNT_W-1:0];

  logic [1:0]           state;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic [GAP_CNT_W-1:0] gap_cnt;

  assign in_ready = (state == IDLE);
  assign busy     = ~in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mux_din   <= 8'h00;
      mux_sel   <= 3'd0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
    end else begin
      // Strobes are pulses; only a SHIFT tick re-asserts them below.
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            mux_din <= in_data;
            mux_sel <= SEL_START;
            bit_cnt <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          if (tick) begin
            ser_out   <= mux_z;
            ser_valid <= 1'b1;
            ser_last  <= (bit_cnt == 3'd7);
            // Eight steps bring the select back to SEL_START.
            mux_sel   <= sel_step(mux_sel, LSB_FIRST);
            bit_cnt   <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              gap_cnt <= '0;
              state   <= SKIP_GAP ? IDLE : GAP;
            end
          end
        end
        GAP: begin
          if (tick) begin
            gap_cnt <= gap_cnt + 4'd1;
            if (gap_cnt == GAP_LAST) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mux8_serializer_ctrl.sv
// ============================================================================
// tb_mux8_serializer_ctrl : scoreboard bench, three configurations of the
// serializer (LSB-first gap 2, MSB-first gap 2, wrapper with gap 0). Rev 1.0
// ============================================================================
`default_nettype none

module tb_mux8_serializer_ctrl;

  typedef struct packed {
    logic       b;
    logic       last;
    logic [2:0] sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: LSB first, 2 gap ticks
  logic a_valid = 0, a_tick = 0, a_ready, a_out, a_sv, a_sl, a_busy, a_z;
  logic [7:0] a_data = 0, a_din;
  logic [2:0] a_sel;
  assign a_z = a_din[a_sel];
  mux8_serializer_ctrl #(.LSB_FIRST(1'b1), .GAP_TICKS(2)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
    .tick(a_tick), .mux_din(a_din), .mux_sel(a_sel), .mux_z(a_z), .ser_out(a_out),
    .ser_valid(a_sv), .ser_last(a_sl), .busy(a_busy));

  // DUT B: MSB first, 2 gap ticks
  logic b_valid = 0, b_tick = 0, b_ready, b_out, b_sv, b_sl, b_busy, b_z;
  logic [7:0] b_data = 0, b_din;
  logic [2:0] b_sel;
  assign b_z = b_din[b_sel];
  mux8_serializer_ctrl #(.LSB_FIRST(1'b0), .GAP_TICKS(2)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
    .tick(b_tick), .mux_din(b_din), .mux_sel(b_sel), .mux_z(b_z), .ser_out(b_out),
    .ser_valid(b_sv), .ser_last(b_sl), .busy(b_busy));

  // DUT C: integration wrapper, no gap
  logic c_valid = 0, c_tick = 0, c_ready, c_out, c_sv, c_sl, c_busy;
  logic [7:0] c_data = 0;
  mux8_serial_tx #(.LSB_FIRST(1'b1), .GAP_TICKS(0)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready), .in_data(c_data),
    .tick(c_tick), .ser_out(c_out), .ser_valid(c_sv), .ser_last(c_sl), .busy(c_busy));

  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  int   a_pulses = 0, b_pulses = 0, c_pulses = 0;
  int   b_last_cyc = 0;
  int   c_cyc[16];
  logic [2:0] a_prev_sel = 0, b_prev_sel = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitors sample at the falling edge; the select used for a bit is the one
  // seen one falling edge earlier.
  always @(negedge clk) begin
    if (a_sv) begin
      a_pulses++;
      if (qa.size() == 0) check("a_unexpected_bit", a_sv, 0);
      else begin
        ea = qa.pop_front();
        check("a_ser_out", a_out, ea.b);
        check("a_ser_last", a_sl, ea.last);
        check("a_sel_used", a_prev_sel, ea.sel);
      end
    end
    a_prev_sel = a_sel;
  end

  always @(negedge clk) begin
    if (b_sv) begin
      if (b_pulses > 0) check("b_spacing", cyc - b_last_cyc, 3);
      b_last_cyc = cyc;
      b_pulses++;
      if (qb.size() == 0) check("b_unexpected_bit", b_sv, 0);
      else begin
        eb = qb.pop_front();
        check("b_ser_out", b_out, eb.b);
        check("b_ser_last", b_sl, eb.last);
        check("b_sel_used", b_prev_sel, eb.sel);
      end
    end
    b_prev_sel = b_sel;
  end

  always @(negedge clk) begin
    if (c_sv) begin
      if (c_pulses < 16) c_cyc[c_pulses] = cyc;
      c_pulses++;
      if (qc.size() == 0) check("c_unexpected_bit", c_sv, 0);
      else begin
        ec = qc.pop_front();
        check("c_ser_out", c_out, ec.b);
        check("c_ser_last", c_sl, ec.last);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w;
    int saved;

    // Reset values
    step();
    check("rst_a_ready", a_ready, 1);
    check("rst_a_busy", a_busy, 0);
    check("rst_a_din", a_din, 0);
    check("rst_a_sel", a_sel, 0);
    check("rst_a_out", {a_out, a_sv, a_sl}, 0);
    check("rst_b_sel", b_sel, 0);
    check("rst_c_ready", c_ready, 1);
    rst = 0;
    step();

    // A5, LSB first, tick=1 constant including the accept cycle
    w = 8'hA5;
    a_valid = 1; a_data = w; a_tick = 1;
    for (int k = 0; k < 8; k++) qa.push_back('{b: w[k], last: (k == 7), sel: 3'(k)});
    step();
    check("a_accept_no_valid", a_sv, 0);
    check("a_accept_busy", a_busy, 1);
    check("a_accept_din", a_din, 8'hA5);
    a_valid = 0;
    repeat (8) step();
    check("a_t1_pulses", a_pulses, 8);
    check("a_t1_busy_after_last", a_busy, 1);
    step();
    check("a_t1_busy_gap1", a_busy, 1);
    step();
    check("a_t1_busy_done", a_busy, 0);
    check("a_t1_sel_wrapped", a_sel, 0);
    check("a_t1_q_empty", qa.size(), 0);

    // Data changing during SHIFT is ignored
    w = 8'h5A;
    a_valid = 1; a_data = w; a_tick = 0;
    for (int k = 0; k < 8; k++) qa.push_back('{b: w[k], last: (k == 7), sel: 3'(k)});
    step();
    for (int i = 0; i < 16; i++) begin
      a_tick = i[0];
      a_data = 8'($urandom);
      step();
      check("a_t4_ready_low", a_ready, 0);
      check("a_t4_din_held", a_din, 8'h5A);
    end
    a_valid = 0; a_tick = 1;
    for (int i = 0; i < 20 && !a_ready; i++) step();
    check("a_t4_return_idle", a_ready, 1);
    check("a_t4_q_empty", qa.size(), 0);

    // Reset after the 4th bit of 3C
    w = 8'h3C;
    a_valid = 1; a_data = w; a_tick = 1;
    for (int k = 0; k < 4; k++) qa.push_back('{b: w[k], last: 1'b0, sel: 3'(k)});
    step();
    a_valid = 0;
    repeat (4) step();
    saved = a_pulses;
    rst = 1;
    #1;
    check("a_t5_ready", a_ready, 1);
    check("a_t5_busy", a_busy, 0);
    check("a_t5_din", a_din, 0);
    check("a_t5_sel", a_sel, 0);
    check("a_t5_out", {a_out, a_sv, a_sl}, 0);
    step(); step();
    rst = 0;
    repeat (12) step();
    check("a_t5_no_pulses", a_pulses, saved);
    check("a_t5_idle", a_ready, 1);
    check("a_t5_q_empty", qa.size(), 0);
    a_tick = 0;

    // 81, MSB first, tick every 3rd cycle
    w = 8'h81;
    b_valid = 1; b_data = w; b_tick = 0;
    for (int k = 0; k < 8; k++) qb.push_back('{b: w[7-k], last: (k == 7), sel: 3'(7 - k)});
    step();
    b_valid = 0;
    check("b_start_sel", b_sel, 7);
    for (int j = 0; j < 30; j++) begin
      b_tick = (j % 3 == 2);
      step();
    end
    b_tick = 0;
    check("b_t2_busy_done", b_busy, 0);
    check("b_t2_pulses", b_pulses, 8);
    check("b_t2_sel_wrapped", b_sel, 7);
    check("b_t2_q_empty", qb.size(), 0);

    // FF then 00 with in_valid held, no gap
    c_valid = 1; c_data = 8'hFF; c_tick = 1;
    for (int k = 0; k < 8; k++) qc.push_back('{b: 1'b1, last: (k == 7), sel: 3'(k)});
    for (int k = 0; k < 8; k++) qc.push_back('{b: 1'b0, last: (k == 7), sel: 3'(k)});
    step();
    c_data = 8'h00;
    check("c_t3_ready_low", c_ready, 0);
    repeat (8) step();
    check("c_t3_last_seen", c_sl, 1);
    check("c_t3_ready_after_last", c_ready, 1);
    step();
    check("c_t3_second_accept", c_ready, 0);
    c_valid = 0;
    repeat (10) step();
    c_tick = 0;
    check("c_t3_pulses", c_pulses, 16);
    check("c_t3_busy_done", c_busy, 0);
    check("c_t3_word1_contig", c_cyc[7] - c_cyc[0], 7);
    check("c_t3_word2_contig", c_cyc[15] - c_cyc[8], 7);
    check("c_t3_word_spacing", c_cyc[8] - c_cyc[7], 2);
    check("c_t3_q_empty", qc.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
